// File: rtl/model_loader_pkg.sv
// Shared constants and types for the SD model loader's DDR write path.
package model_loader_pkg;

    localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int AXI_DATA_W = 128;
    localparam int LANES      = AXI_DATA_W / 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } wr_state_e;

endpackage

// File: rtl/model_sync_fifo.sv
// First-word-fall-through synchronous FIFO; rdata_o shows the head entry whenever count_o > 0.
module model_sync_fifo #(
    parameter int WIDTH = 144,
    parameter int DEPTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             empty;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit distinguishes full from empty.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == (AW + 1)'(DEPTH));
    assign empty   = (count_o == '0);
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/model_ddr_writer.sv
// Packs the 16-bit model stream into 128-bit words and commits them to DDR
// as AXI4 INCR bursts, pulsing done once the last write response returns.
module model_ddr_writer
    import model_loader_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 128,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                ddr_wr_en,
    input  logic [15:0]         ddr_wr_data,
    input  logic                ddr_wr_last,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                error,
    output logic [23:0]         words_written
);
    localparam int STRB_W = DATA_W / 8;
    localparam int FW     = DATA_W + STRB_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam int LANE_W = $clog2(LANES);

    localparam logic [CNT_W-1:0]  BURST_CNT   = CNT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] BURST_BEATS = BEAT_W'(BURST_LEN);

    // ---------------- packer ----------------
    logic [LANES-1:0][15:0] pack_data_q, pack_data_d, word_data;
    logic [LANES-1:0][1:0]  pack_strb_q, pack_strb_d, word_strb;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic                   push;

    logic [FW-1:0]          fifo_rdata;
    logic [CNT_W-1:0]       fifo_cnt;
    logic                   fifo_full;
    logic                   fifo_rd;

    always_comb begin
        pack_data_d = pack_data_q;
        pack_strb_d = pack_strb_q;
        lane_d      = lane_q;
        word_data   = pack_data_q;
        word_strb   = pack_strb_q;
        push        = 1'b0;
        if (busy && ddr_wr_en) begin
            word_data[lane_q] = ddr_wr_data;
            word_strb[lane_q] = 2'b11;
            if (lane_q == LANE_W'(LANES - 1)) begin
                push        = 1'b1;
                pack_data_d = '0;
                pack_strb_d = '0;
                lane_d      = '0;
            end else begin
                pack_data_d = word_data;
                pack_strb_d = word_strb;
                lane_d      = lane_q + 1'b1;
            end
        end else if (busy && ddr_wr_last && lane_q != '0) begin
            // Flush of a partial word: unfilled lanes are already zero with strobe clear.
            push        = 1'b1;
            pack_data_d = '0;
            pack_strb_d = '0;
            lane_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_data_q <= '0;
            pack_strb_q <= '0;
            lane_q      <= '0;
        end else if (start && !busy) begin
            pack_data_q <= '0;
            pack_strb_q <= '0;
            lane_q      <= '0;
        end else begin
            pack_data_q <= pack_data_d;
            pack_strb_q <= pack_strb_d;
            lane_q      <= lane_d;
        end
    end

    model_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .wr_en_i (push && !fifo_full),
        .wdata_i ({word_strb, word_data}),
        .rd_en_i (fifo_rd),
        .rdata_o (fifo_rdata),
        .count_o (fifo_cnt),
        .full_o  (fifo_full)
    );

    // ---------------- AXI write FSM ----------------
    wr_state_e         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [7:0]        awlen_q;
    logic [BEAT_W-1:0] beats_q;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] burst_beats;
    logic              awvalid_q, wvalid_q, wlast_q, bready_q;
    logic              busy_q, done_q, overflow_q, error_q, last_seen_q;
    logic [23:0]       words_q;
    logic              last_now;
    logic              ready_burst;

    assign burst_beats = (fifo_cnt >= BURST_CNT) ? BURST_BEATS : fifo_cnt[BEAT_W-1:0];
    assign ready_burst = (fifo_cnt >= BURST_CNT) || (last_seen_q && fifo_cnt != '0);
    // Lets an empty transfer finish without waiting a cycle for last_seen_q.
    assign last_now    = last_seen_q || (ddr_wr_last && !ddr_wr_en);
    assign fifo_rd     = wvalid_q && m_axi_wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            beats_q     <= '0;
            beat_q      <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            error_q     <= 1'b0;
            last_seen_q <= 1'b0;
            words_q     <= '0;
        end else begin
            if (start && !busy_q) begin
                addr_q      <= base_addr & ~ADDR_W'(8'hFF);
                overflow_q  <= 1'b0;
                error_q     <= 1'b0;
                words_q     <= '0;
                last_seen_q <= 1'b0;
                busy_q      <= 1'b1;
            end
            if (busy_q && ddr_wr_last && !ddr_wr_en) last_seen_q <= 1'b1;
            if (push && fifo_full) overflow_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (busy_q && ready_burst) begin
                        beats_q   <= burst_beats;
                        awlen_q   <= 8'(burst_beats - BEAT_W'(1));
                        awaddr_q  <= addr_q;
                        awvalid_q <= 1'b1;
                        state_q   <= ST_AW;
                    end else if (busy_q && last_now && fifo_cnt == '0 && lane_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_AW: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= (beats_q == BEAT_W'(1));
                        beat_q    <= '0;
                        state_q   <= ST_W;
                    end
                end
                ST_W: begin
                    if (m_axi_wready) begin
                        words_q <= words_q + 24'd1;
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= ST_B;
                        end else begin
                            beat_q  <= beat_q + 1'b1;
                            wlast_q <= (beat_q + BEAT_W'(2) == beats_q);
                        end
                    end
                end
                ST_B: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        addr_q   <= addr_q + (ADDR_W'(beats_q) << 4);
                        if (m_axi_bresp != AXI_RESP_OKAY) error_q <= 1'b1;
                        if (last_seen_q && fifo_cnt == '0 && lane_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = AXI_SIZE_16B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = fifo_rdata[DATA_W-1:0];
    assign m_axi_wstrb   = fifo_rdata[FW-1:DATA_W];
    assign m_axi_wlast   = wlast_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign error         = error_q;
    assign words_written = words_q;

endmodule

// File: doc/model_ddr_writer.md
Name: model_ddr_writer

Overview:
Downstream stage of the SD model reader. It takes the 16-bit write stream (ddr_wr_en / ddr_wr_data / ddr_wr_last) and packs 8 halfwords into 128-bit words. Words are buffered in a FIFO and written to DDR as AXI4 INCR write bursts starting at a programmable base address. It signals completion once every word of the model image is committed and the final write response has been received.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 128, AXI data width; fixed 8 halfword lanes
BURST_LEN, 16, maximum beats per AXI burst; power of two, at most 16
FIFO_DEPTH, 64, packed-word FIFO depth in words; power of two, at least 2*BURST_LEN

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a transfer; ignored while busy
base_addr  in  ADDR_W  DDR destination; bits [7:0] treated as zero
ddr_wr_en  in  1  input halfword valid; no backpressure
ddr_wr_data  in  16  input halfword
ddr_wr_last  in  1  level; high once upstream has issued its final halfword
m_axi_awaddr  out  ADDR_W  burst address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  constant 3'b100
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid  out  1
m_axi_awready  in  1
m_axi_wdata  out  DATA_W
m_axi_wstrb  out  DATA_W/8
m_axi_wlast  out  1
m_axi_wvalid  out  1
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1
busy  out  1  high from start until done
done  out  1  one-cycle completion pulse
overflow  out  1  sticky; a packed word was dropped
error  out  1  sticky; a nonzero bresp was received
words_written  out  24  count of beats accepted on the W channel

Behaviour:
- Reset (asynchronous, rst_n low) clears all valids, done, busy, overflow, error, words_written, awaddr, the packer and the FIFO. This happens immediately, mid-burst included. Constant outputs keep their constant values.
- Start (only while not busy):
  - latch {base_addr[ADDR_W-1:8], 8'h00} as the next address;
  - clear overflow, error and words_written;
  - set busy.
- Packer: active only while busy.
  - Halfword k (k = 0..7) goes to bits [16k+15:16k]; strobe bits [2k+1:2k] are set for that lane.
  - When the 8th halfword arrives, push {strb=16'hFFFF, data} into the FIFO on the next edge, and the lane counter wraps to 0.
- Flush: when ddr_wr_last is high, no ddr_wr_en is present that cycle, and the lane counter is nonzero, push the partial word once.
  - Unused lanes are zero with strb=0.
  - If ddr_wr_en and ddr_wr_last are high together, the halfword is taken first; the flush follows on a later cycle.
- last_seen is set when ddr_wr_last is high with the packer empty or flushed.
- FIFO full at a push: the word is dropped and overflow is set sticky. There is no stall path.
- FSM states: IDLE, AW, W, B, DONE.
  - IDLE → AW when busy and (fifo_count >= BURST_LEN, or last_seen and fifo_count > 0).
    - beats = min(fifo_count, BURST_LEN); awlen = beats-1.
    - awaddr and awlen are registered and stable while awvalid is high.
  - AW: awvalid=1 until awready → W.
  - W: wvalid=1 (the FIFO holds at least beats words). Pop on each wvalid&wready. wlast is asserted on beat beats-1 → B. words_written increments per accepted beat.
  - B: bready=1. On bvalid, set error if bresp!=2'b00, and add beats*16 to the address.
    - → DONE if last_seen, the FIFO is empty and the packer is empty;
    - else → IDLE.
  - DONE: done=1 for exactly one cycle and busy clears → IDLE.
- AW and W are strictly sequential; wvalid is never raised before the AW handshake.
- Bursts never cross a 4 KB boundary (base is 256 B aligned, and each burst is at most 256 B).
- A zero-length transfer (ddr_wr_last already high at start, no data) → DONE in the cycle after start, with no AXI traffic.

Decomposition:
- Shared package (model_loader_pkg):
  - AXI_SIZE_16B = 3'b100, AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00;
  - FSM state encoding;
  - LANES = DATA_W/16.
- One sub-module, model_sync_fifo: synchronous FIFO, width DATA_W+DATA_W/8, FIFO_DEPTH deep, with a count output.

Test Plan:
- 256 halfwords 0x0000..0x00FF, then last, base 0x1000_0000, ready always high → bursts at 0x1000_0000 and 0x1000_0100, both awlen=15. The first beat's wdata = 0x0007_0006_..._0000. words_written=32, one done pulse, error=0.
- 20 halfwords, then last → one burst, awlen=2. The third beat has wstrb=16'h00FF with its upper 64 bits zero. done pulses.
- Continuous input with awready held low for 10 cycles, then released → no overflow; all 64 words are written in order.
- wready held low while 600 halfwords stream in → overflow=1 and the FIFO is capped at 64 words. After release, done still pulses.
- bresp=2'b10 on the first burst of a 2-burst transfer → error=1 sticky, the second burst still issues, done pulses.
- rst_n low mid-W-burst → awvalid, wvalid and busy drop asynchronously. A subsequent start with base 0x2000_0000 writes correctly from lane 0.
